score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/pong_pkg.sv | 17 +
 rtl/frame_timer.sv | 32 +++
 rtl/score_keeper.sv | 110 +++++++++++
 tb/tb_score_keeper.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong score keeper: FSM state encoding,
// score width and default game parameters.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int SCORE_W          = 4;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_SERVE_FRAMES = 60;

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter stepped by the frame strobe; done is high while the
// count is zero.
module frame_timer
    import pong_pkg::*;
#(
    parameter int FRAMES = DEF_SERVE_FRAMES,
    parameter int W      = $clog2(FRAMES + 1)
) (
    input  logic clk_pix,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    input  logic frame,
    output logic done
);

    logic [W-1:0] count;

    // load wins over a coincident strobe so a fresh reload is never shortened
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(FRAMES);
        end else if (en && frame && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: serve delay, point scoring and game-over detection.
// Define SCORE_AUTOSERVE_EN to leave SERVE as soon as the delay expires.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic               frame,
    input  logic               miss_l,
    input  logic               miss_r,
    input  logic               btn_start,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               play,
    output logic               game_over,
    output logic               winner,
    output state_t             state_dbg
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             state, state_n;
    logic [SCORE_W-1:0] score_l_n, score_r_n;
    logic               btn_q, btn_rise;
    logic               load, done;

    assign btn_rise  = btn_start & ~btn_q;
    assign state_dbg = state;

    frame_timer #(.FRAMES(SERVE_FRAMES)) u_timer (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .load    (load),
        .en      (state == SERVE),
        .frame   (frame),
        .done    (done)
    );

    always_comb begin
        state_n   = state;
        score_l_n = score_l;
        score_r_n = score_r;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (btn_rise) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    load      = 1'b1;
                    state_n   = SERVE;
                end
            end
            SERVE: begin
`ifdef SCORE_AUTOSERVE_EN
                if (done) state_n = PLAY;
`else
                if (done && btn_rise) state_n = PLAY;
`endif
            end
            PLAY: begin
                // a simultaneous double miss is a void rally
                if (miss_l || miss_r) begin
                    state_n = POINT;
                    if (miss_r && !miss_l) score_l_n = score_l + SCORE_W'(1);
                    if (miss_l && !miss_r) score_r_n = score_r + SCORE_W'(1);
                end
            end
            POINT: begin
                if (score_l == WIN || score_r == WIN) begin
                    state_n = GAME_OVER;
                end else begin
                    load    = 1'b1;
                    state_n = SERVE;
                end
            end
            GAME_OVER: begin
                if (btn_rise) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            score_l   <= '0;
            score_r   <= '0;
            btn_q     <= 1'b0;
            play      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            state     <= state_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            btn_q     <= btn_start;
            play      <= (state_n == PLAY);
            game_over <= (state_n == GAME_OVER);
            winner    <= (state_n == GAME_OVER) && (score_l_n != WIN);
        end
    end

    // a point is only scorable while both players are still below the target
    a_no_score_at_win: assert property (@(posedge clk_pix) disable iff (!rst_n)
        (state == PLAY) |-> (score_l < WIN && score_r < WIN));

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: table of PLAY-cycle miss vectors plus
// hand-written serve, game-over and reset sequences.
module tb_score_keeper;
    import pong_pkg::*;

    logic               clk_pix   = 1'b0;
    logic               rst_n     = 1'b0;
    logic               frame     = 1'b0;
    logic               miss_l    = 1'b0;
    logic               miss_r    = 1'b0;
    logic               btn_start = 1'b0;
    logic [SCORE_W-1:0] score_l, score_r;
    logic               play, game_over, winner;
    state_t             state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic   ml;
        logic   mr;
        int     hold;
        int     dl;
        int     dr;
        state_t st_hit;
        state_t st_after;
    } vec_t;

    vec_t vecs[5];

    always #5 clk_pix = ~clk_pix;

    score_keeper #(.WIN_SCORE(9), .SERVE_FRAMES(60)) dut (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .frame     (frame),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .btn_start (btn_start),
        .score_l   (score_l),
        .score_r   (score_r),
        .play      (play),
        .game_over (game_over),
        .winner    (winner),
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            tick();
        end
    endtask

    task automatic press();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        tick();
    endtask

    task automatic serve_to_play();
        send_frames(60);
        tick();
`ifndef SCORE_AUTOSERVE_EN
        press();
`endif
        check("serve_to_play", int'(play), 1);
    endtask

    task automatic score_point(input bit to_left, input bit serve_after);
        miss_r = to_left;
        miss_l = !to_left;
        tick();
        miss_r = 1'b0;
        miss_l = 1'b0;
        tick();
        if (serve_after) serve_to_play();
    endtask

    initial begin
        int sl0, sr0;

        vecs[0] = '{ml: 1'b0, mr: 1'b0, hold: 3,   dl: 0, dr: 0, st_hit: PLAY,  st_after: PLAY};
        vecs[1] = '{ml: 1'b0, mr: 1'b1, hold: 500, dl: 1, dr: 0, st_hit: POINT, st_after: SERVE};
        vecs[2] = '{ml: 1'b1, mr: 1'b1, hold: 1,   dl: 0, dr: 0, st_hit: POINT, st_after: SERVE};
        vecs[3] = '{ml: 1'b1, mr: 1'b0, hold: 1,   dl: 0, dr: 1, st_hit: POINT, st_after: SERVE};
        vecs[4] = '{ml: 1'b1, mr: 1'b1, hold: 40,  dl: 0, dr: 0, st_hit: POINT, st_after: SERVE};

        // reset state
        repeat (3) tick();
        check("rst_state", int'(state_dbg), int'(IDLE));
        check("rst_score_l", int'(score_l), 0);
        check("rst_score_r", int'(score_r), 0);
        check("rst_play", int'(play), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_winner", int'(winner), 0);
        rst_n = 1'b1;
        tick();

        // start with a frame strobe on the entry cycle; it must not count
        btn_start = 1'b1;
        frame     = 1'b1;
        tick();
        btn_start = 1'b0;
        frame     = 1'b0;
        tick();
        check("start_state", int'(state_dbg), int'(SERVE));
        send_frames(59);
        frame = 1'b1;
        tick();
        check("play_at_expiry", int'(play), 0);
        frame = 1'b0;
        tick();
`ifdef SCORE_AUTOSERVE_EN
        check("play_after_expiry", int'(play), 1);
`else
        check("play_after_expiry", int'(play), 0);
        repeat (3) tick();
        check("play_wait_btn", int'(play), 0);
        press();
        check("play_after_btn", int'(play), 1);
`endif
        check("start_score_l", int'(score_l), 0);
        check("start_score_r", int'(score_r), 0);

        // miss decoding in PLAY, including long held levels
        for (int v = 0; v < 5; v++) begin
            sl0    = int'(score_l);
            sr0    = int'(score_r);
            miss_l = vecs[v].ml;
            miss_r = vecs[v].mr;
            tick();
            check($sformatf("vec%0d_hit_state", v), int'(state_dbg), int'(vecs[v].st_hit));
            check($sformatf("vec%0d_hit_l", v), int'(score_l), sl0 + vecs[v].dl);
            check($sformatf("vec%0d_hit_r", v), int'(score_r), sr0 + vecs[v].dr);
            repeat (vecs[v].hold - 1) tick();
            miss_l = 1'b0;
            miss_r = 1'b0;
            tick();
            check($sformatf("vec%0d_after_state", v), int'(state_dbg), int'(vecs[v].st_after));
            check($sformatf("vec%0d_after_l", v), int'(score_l), sl0 + vecs[v].dl);
            check($sformatf("vec%0d_after_r", v), int'(score_r), sr0 + vecs[v].dr);
            check($sformatf("vec%0d_after_play", v), int'(play), (vecs[v].st_after == PLAY) ? 1 : 0);
            if (vecs[v].st_after == SERVE) serve_to_play();
        end

        // right player wins from 1/1
        for (int i = 0; i < 8; i++) score_point(1'b0, i < 7);
        check("rwin_game_over", int'(game_over), 1);
        check("rwin_winner", int'(winner), 1);
        check("rwin_score_r", int'(score_r), 9);
        check("rwin_score_l", int'(score_l), 1);
        check("rwin_play", int'(play), 0);
        miss_l = 1'b1;
        repeat (10) tick();
        miss_l = 1'b0;
        miss_r = 1'b1;
        repeat (10) tick();
        miss_r = 1'b0;
        tick();
        check("rwin_hold_r", int'(score_r), 9);
        check("rwin_hold_l", int'(score_l), 1);
        check("rwin_hold_state", int'(state_dbg), int'(GAME_OVER));
        press();
        check("rwin_to_idle", int'(state_dbg), int'(IDLE));
        check("rwin_idle_go", int'(game_over), 0);

        // reach 3/5, then reset at serve frame 30
        press();
        check("new_game_l", int'(score_l), 0);
        check("new_game_r", int'(score_r), 0);
        serve_to_play();
        for (int i = 0; i < 3; i++) score_point(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) score_point(1'b0, i < 4);
        check("mid_score_l", int'(score_l), 3);
        check("mid_score_r", int'(score_r), 5);
        send_frames(30);
        check("mid_state", int'(state_dbg), int'(SERVE));
        rst_n = 1'b0;
        #1;
        check("arst_state", int'(state_dbg), int'(IDLE));
        check("arst_score_l", int'(score_l), 0);
        check("arst_score_r", int'(score_r), 0);
        check("arst_play", int'(play), 0);
        check("arst_game_over", int'(game_over), 0);
        check("arst_winner", int'(winner), 0);
        tick();
        rst_n = 1'b1;
        send_frames(70);
        miss_r = 1'b1;
        repeat (5) tick();
        miss_r = 1'b0;
        tick();
        check("post_rst_state", int'(state_dbg), int'(IDLE));
        check("post_rst_play", int'(play), 0);
        check("post_rst_score_l", int'(score_l), 0);

`ifndef SCORE_AUTOSERVE_EN
        // button before expiry is ignored, after expiry it serves
        press();
        send_frames(10);
        press();
        check("early_btn_state", int'(state_dbg), int'(SERVE));
        send_frames(60);
        check("late_wait_state", int'(state_dbg), int'(SERVE));
        press();
        check("late_btn_state", int'(state_dbg), int'(PLAY));
        check("late_btn_play", int'(play), 1);
`else
        press();
        serve_to_play();
`endif

        // left player wins from 0/0
        for (int i = 0; i < 9; i++) score_point(1'b1, i < 8);
        check("lwin_game_over", int'(game_over), 1);
        check("lwin_winner", int'(winner), 0);
        check("lwin_score_l", int'(score_l), 9);
        check("lwin_score_r", int'(score_r), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
